// File: rtl/cache_define.sv
// Shared definitions for the 4-way cache: widths, address slicing, way codes,
// refill FSM states and the tree pseudo-LRU helper functions.
package cache_define;

    localparam int ADDR_WIDTH     = 8;
    localparam int TAG_WIDTH      = 4;
    localparam int INDEX_WIDTH    = 4;
    localparam int LINE_NUM       = 1 << INDEX_WIDTH;
    localparam int WAY_NUM        = 4;
    localparam int WAY_CODE_WIDTH = $clog2(WAY_NUM) + 1;
    localparam int PLRU_WIDTH     = WAY_NUM - 1;

    localparam int INDEX_MSB = ADDR_WIDTH - 1;
    localparam int INDEX_LSB = ADDR_WIDTH - INDEX_WIDTH;
    localparam int TAG_MSB   = TAG_WIDTH - 1;
    localparam int TAG_LSB   = 0;

    typedef logic [WAY_CODE_WIDTH-1:0] way_code_t;
    typedef logic [PLRU_WIDTH-1:0]     plru_bits_t;

    localparam way_code_t REPLACE_WAY0 = 3'd0;
    localparam way_code_t REPLACE_WAY1 = 3'd1;
    localparam way_code_t REPLACE_WAY2 = 3'd2;
    localparam way_code_t REPLACE_WAY3 = 3'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        REFILL   = 2'd3
    } refill_state_t;

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[INDEX_MSB:INDEX_LSB];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[TAG_MSB:TAG_LSB];
    endfunction

    // b0 picks the pair, b1 picks within ways 0/1, b2 picks within ways 2/3.
    function automatic way_code_t plru_victim(input plru_bits_t bits);
        if (!bits[0])
            return bits[1] ? REPLACE_WAY1 : REPLACE_WAY0;
        else
            return bits[2] ? REPLACE_WAY3 : REPLACE_WAY2;
    endfunction

    function automatic plru_bits_t plru_touch(input plru_bits_t bits, input way_code_t way);
        plru_bits_t nxt;
        nxt = bits;
        case (way)
            REPLACE_WAY0: begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
            REPLACE_WAY1: begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
            REPLACE_WAY2: begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
            REPLACE_WAY3: begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
            default:      nxt = bits;
        endcase
        return nxt;
    endfunction

    // Several ways hitting at once is tolerated; the lowest one wins.
    function automatic way_code_t lowest_hit(input logic [WAY_NUM-1:0] hit);
        if (hit[0])      return REPLACE_WAY0;
        else if (hit[1]) return REPLACE_WAY1;
        else if (hit[2]) return REPLACE_WAY2;
        else             return REPLACE_WAY3;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Core-side access port, memory fetch handshake and refill outputs of the
// cache refill controller, bundled with controller (slave) and environment (master) views.
interface cache_refill_ctrl_if;
    import cache_define::*;

    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WAY_NUM-1:0]    hit_en;
    logic                  req_done;
    logic                  busy;
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic                  read_main_memory_en;
    logic [ADDR_WIDTH-1:0] addr_to_main_memory;
    way_code_t             replaced_way;

    modport slave (
        input  req_valid, req_addr, hit_en, mem_req_ready, mem_resp_valid,
        output req_done, busy, mem_req_valid, mem_req_addr,
               read_main_memory_en, addr_to_main_memory, replaced_way
    );

    modport master (
        output req_valid, req_addr, hit_en, mem_req_ready, mem_resp_valid,
        input  req_done, busy, mem_req_valid, mem_req_addr,
               read_main_memory_en, addr_to_main_memory, replaced_way
    );

endinterface

// File: rtl/cache_plru.sv
// Per-set 3-bit tree pseudo-LRU store: combinational victim lookup for one
// index and a single update port.
module cache_plru
    import cache_define::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_WIDTH-1:0] query_index,
    output way_code_t              victim,
    input  logic                   upd_en,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  way_code_t              upd_way
);

    plru_bits_t plru [LINE_NUM];

    assign victim = plru_victim(plru[query_index]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_NUM; i++)
                plru[i] <= '0;
        end else if (upd_en) begin
            plru[upd_index] <= plru_touch(plru[upd_index], upd_way);
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss handler for the 4-way cache: answers hits, fetches missing lines over a
// valid/ready handshake and issues a one-cycle refill strobe with the victim way.
module cache_refill_ctrl
    import cache_define::*;
(
    input  logic              clk,
    input  logic              rst_n,
    cache_refill_ctrl_if.slave bus
);

    refill_state_t         state;
    logic [ADDR_WIDTH-1:0] miss_addr;
    way_code_t             victim_q;
    way_code_t             lookup_victim;
    logic                  lookup_hit;
    logic                  miss_start;
    logic                  upd_en;
    logic [INDEX_WIDTH-1:0] upd_index;
    way_code_t             upd_way;

    assign lookup_hit = (state == IDLE) && bus.req_valid && (|bus.hit_en);
    assign miss_start = (state == IDLE) && bus.req_valid && !(|bus.hit_en);
    assign bus.req_done = lookup_hit;

    // Hits only count in IDLE and the refill update only happens in REFILL,
    // so one shared update port is enough.
    assign upd_en    = lookup_hit || (state == REFILL);
    assign upd_index = (state == REFILL) ? addr_index(miss_addr) : addr_index(bus.req_addr);
    assign upd_way   = (state == REFILL) ? victim_q : lowest_hit(bus.hit_en);

    cache_plru u_plru (
        .clk         (clk),
        .rst_n       (rst_n),
        .query_index (addr_index(bus.req_addr)),
        .victim      (lookup_victim),
        .upd_en      (upd_en),
        .upd_index   (upd_index),
        .upd_way     (upd_way)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= IDLE;
            miss_addr               <= '0;
            victim_q                <= REPLACE_WAY0;
            bus.busy                <= 1'b0;
            bus.mem_req_valid       <= 1'b0;
            bus.mem_req_addr        <= '0;
            bus.read_main_memory_en <= 1'b0;
            bus.addr_to_main_memory <= '0;
            bus.replaced_way        <= REPLACE_WAY0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        miss_addr         <= bus.req_addr;
                        victim_q          <= lookup_victim;
                        bus.mem_req_addr  <= bus.req_addr;
                        bus.mem_req_valid <= 1'b1;
                        bus.busy          <= 1'b1;
                        state             <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state             <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        bus.read_main_memory_en <= 1'b1;
                        bus.addr_to_main_memory <= miss_addr;
                        bus.replaced_way        <= victim_q;
                        state                   <= REFILL;
                    end
                end
                REFILL: begin
                    bus.read_main_memory_en <= 1'b0;
                    bus.busy                <= 1'b0;
                    state                   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: misses, victim rotation, hits,
// handshake stalls, withdrawn requests and reset in the middle of a miss.
module tb_cache_refill_ctrl;
    import cache_define::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    cache_refill_ctrl_if bus ();

    cache_refill_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] addr, input logic [3:0] hit);
        bus.req_valid = valid;
        bus.req_addr  = addr;
        bus.hit_en    = hit;
    endtask

    // One complete miss with the given handshake delays, then the retried hit.
    task automatic runMiss(input string tag, input logic [7:0] addr, input int ready_wait,
                           input int resp_wait, input bit withdraw, input logic [2:0] exp_way);
        applyStimulus(1'b1, addr, 4'b0000);
        #1;
        checkOutput({tag, "_miss_no_done"}, bus.req_done, 1'b0);
        tick();
        checkOutput({tag, "_req_valid"}, bus.mem_req_valid, 1'b1);
        checkOutput({tag, "_req_addr"}, bus.mem_req_addr, addr);
        checkOutput({tag, "_busy_req"}, bus.busy, 1'b1);
        applyStimulus(1'b1, 8'hF0, 4'b1111);
        #1;
        checkOutput({tag, "_busy_no_done"}, bus.req_done, 1'b0);
        for (int i = 0; i < ready_wait; i++) begin
            tick();
            checkOutput({tag, "_stall_valid"}, bus.mem_req_valid, 1'b1);
            checkOutput({tag, "_stall_addr"}, bus.mem_req_addr, addr);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        checkOutput({tag, "_wait_valid"}, bus.mem_req_valid, 1'b0);
        checkOutput({tag, "_busy_wait"}, bus.busy, 1'b1);
        if (withdraw)
            applyStimulus(1'b0, 8'hA0, 4'b0000);
        for (int i = 0; i < resp_wait; i++) begin
            tick();
            checkOutput({tag, "_wait_no_strobe"}, bus.read_main_memory_en, 1'b0);
            checkOutput({tag, "_wait_busy"}, bus.busy, 1'b1);
        end
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;
        checkOutput({tag, "_strobe"}, bus.read_main_memory_en, 1'b1);
        checkOutput({tag, "_refill_addr"}, bus.addr_to_main_memory, addr);
        checkOutput({tag, "_victim"}, bus.replaced_way, exp_way);
        checkOutput({tag, "_busy_refill"}, bus.busy, 1'b1);
        tick();
        checkOutput({tag, "_strobe_once"}, bus.read_main_memory_en, 1'b0);
        checkOutput({tag, "_idle"}, bus.busy, 1'b0);
        checkOutput({tag, "_no_second_req"}, bus.mem_req_valid, 1'b0);
        checkOutput({tag, "_addr_hold"}, bus.addr_to_main_memory, addr);
        applyStimulus(1'b1, addr, 4'b0001 << exp_way);
        #1;
        checkOutput({tag, "_retry_hit"}, bus.req_done, 1'b1);
        tick();
        checkOutput({tag, "_retry_no_req"}, bus.mem_req_valid, 1'b0);
        applyStimulus(1'b0, 8'h00, 4'b0000);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        applyStimulus(1'b0, 8'h00, 4'b0000);
        repeat (2) tick();
        checkOutput("rst_busy", bus.busy, 1'b0);
        checkOutput("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
        checkOutput("rst_mem_req_addr", bus.mem_req_addr, 8'h00);
        checkOutput("rst_strobe", bus.read_main_memory_en, 1'b0);
        checkOutput("rst_refill_addr", bus.addr_to_main_memory, 8'h00);
        checkOutput("rst_way", bus.replaced_way, 3'd0);
        checkOutput("rst_done", bus.req_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Cold miss plus rotation through set 3: victims 0,2,1,3.
        runMiss("cold", 8'h35, 0, 0, 1'b0, 3'd0);
        runMiss("rot2", 8'h36, 0, 0, 1'b0, 3'd2);
        runMiss("rot3", 8'h37, 0, 0, 1'b0, 3'd1);
        runMiss("rot4", 8'h38, 0, 0, 1'b0, 3'd3);

        // Hit on way 2 of set 2 points the tree back at way 0.
        applyStimulus(1'b1, 8'h2C, 4'b0100);
        #1;
        checkOutput("hit_done", bus.req_done, 1'b1);
        tick();
        checkOutput("hit_no_req", bus.mem_req_valid, 1'b0);
        checkOutput("hit_not_busy", bus.busy, 1'b0);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        runMiss("after_hit", 8'h21, 0, 0, 1'b0, 3'd0);

        runMiss("stall", 8'h4A, 5, 7, 1'b0, 3'd0);

        // Ways 1 and 2 both hit: way 1 is credited, so the victim is way 2.
        applyStimulus(1'b1, 8'h51, 4'b0110);
        #1;
        checkOutput("multi_hit_done", bus.req_done, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 4'b0000);
        runMiss("multi_hit", 8'h52, 0, 0, 1'b0, 3'd2);

        runMiss("withdraw", 8'h43, 1, 2, 1'b1, 3'd2);

        // Miss abandoned by reset while waiting for the line.
        applyStimulus(1'b1, 8'h22, 4'b0000);
        tick();
        checkOutput("abort_req_valid", bus.mem_req_valid, 1'b1);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        checkOutput("abort_in_wait", bus.busy, 1'b1);
        rst_n = 1'b0;
        #2;
        checkOutput("abort_rst_busy", bus.busy, 1'b0);
        checkOutput("abort_rst_req_addr", bus.mem_req_addr, 8'h00);
        checkOutput("abort_rst_refill_addr", bus.addr_to_main_memory, 8'h00);
        checkOutput("abort_rst_way", bus.replaced_way, 3'd0);
        tick();
        rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;
        checkOutput("abort_no_strobe", bus.read_main_memory_en, 1'b0);
        checkOutput("abort_idle", bus.busy, 1'b0);
        tick();
        checkOutput("abort_no_strobe_late", bus.read_main_memory_en, 1'b0);
        runMiss("post_rst_set2", 8'h23, 0, 0, 1'b0, 3'd0);
        runMiss("post_rst_set4", 8'h44, 0, 0, 1'b0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
